vx_writeback_arbiter: RTL and testbench

- Producer end of the writeback interface consumed by the issue stage (scoreboard release + GPR write).
- Collects per-execution-unit commit streams (ALU, LSU, CSR, FPU, GPU) and arbitrates them round-robin onto a single registered writeback channel.
- Keeps multi-packet instructions (eop=0 … eop=1) atomic.
- Counts retired instructions.

---
 rtl/vx_writeback_arbiter.sv | 159 +++++++++++++++
 tb/tb_vx_writeback_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/vx_writeback_arbiter.sv
// Round-robin arbiter merging execution-unit commit streams onto one registered
// writeback channel; keeps multi-packet instructions atomic and counts retirements.
module vx_writeback_arbiter #(
    parameter int NUM_UNITS   = 5,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int NW_BITS     = 2,
    parameter int NR_BITS     = 6,
    parameter int UUID_BITS   = 44,
    parameter int CTR_BITS    = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_UNITS-1:0]                 in_valid,
    output logic [NUM_UNITS-1:0]                 in_ready,
    input  logic [NUM_UNITS*UUID_BITS-1:0]       in_uuid,
    input  logic [NUM_UNITS*NW_BITS-1:0]         in_wid,
    input  logic [NUM_UNITS*NUM_THREADS-1:0]     in_tmask,
    input  logic [NUM_UNITS*32-1:0]              in_PC,
    input  logic [NUM_UNITS-1:0]                 in_wb,
    input  logic [NUM_UNITS*NR_BITS-1:0]         in_rd,
    input  logic [NUM_UNITS*NUM_THREADS*XLEN-1:0] in_data,
    input  logic [NUM_UNITS-1:0]                 in_eop,
    output logic                                 wb_valid,
    input  logic                                 wb_ready,
    output logic [UUID_BITS-1:0]                 wb_uuid,
    output logic [NW_BITS-1:0]                   wb_wid,
    output logic [NUM_THREADS-1:0]               wb_tmask,
    output logic [31:0]                          wb_PC,
    output logic [NR_BITS-1:0]                   wb_rd,
    output logic [NUM_THREADS*XLEN-1:0]          wb_data,
    output logic                                 wb_eop,
    output logic [CTR_BITS-1:0]                  retired
);

    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int DW = NUM_THREADS * XLEN;

    logic [UW-1:0]            rr;
    logic [UW-1:0]            lock_unit;
    logic                     lock;
    logic [UW-1:0]            grant_idx;
    logic                     grant_vld;
    logic [UW:0]              cand;
    logic [2*NUM_UNITS-1:0]   valid_rot;
    logic                     can_load;
    logic                     accept;
    logic [UW-1:0]            next_rr;

    logic [UUID_BITS-1:0]     sel_uuid;
    logic [NW_BITS-1:0]       sel_wid;
    logic [NUM_THREADS-1:0]   sel_tmask;
    logic [31:0]              sel_PC;
    logic                     sel_wb;
    logic [NR_BITS-1:0]       sel_rd;
    logic [DW-1:0]            sel_data;
    logic                     sel_eop;

    // Grant stage: locked unit wins outright, otherwise scan from rr.
    assign valid_rot = {in_valid, in_valid} >> rr;

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (lock) begin
            grant_idx = lock_unit;
            for (int i = 0; i < NUM_UNITS; i++)
                if (lock_unit == UW'(i))
                    grant_vld = in_valid[i];
        end else begin
            // Descending scan so the closest unit to rr is the last writer.
            for (int k = NUM_UNITS - 1; k >= 0; k--) begin
                cand = {1'b0, rr} + (UW+1)'(k);
                if (cand >= (UW+1)'(NUM_UNITS))
                    cand = cand - (UW+1)'(NUM_UNITS);
                if (valid_rot[k]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[UW-1:0];
                end
            end
        end
    end

    assign can_load = ~wb_valid | wb_ready;
    assign accept   = grant_vld & can_load & ~reset;
    assign next_rr  = (grant_idx == UW'(NUM_UNITS - 1)) ? '0 : grant_idx + UW'(1);

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_UNITS; i++)
            in_ready[i] = accept && (grant_idx == UW'(i));
    end

    always_comb begin
        sel_uuid  = '0;
        sel_wid   = '0;
        sel_tmask = '0;
        sel_PC    = '0;
        sel_wb    = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        sel_eop   = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (grant_idx == UW'(i)) begin
                sel_uuid  = in_uuid[i*UUID_BITS +: UUID_BITS];
                sel_wid   = in_wid[i*NW_BITS +: NW_BITS];
                sel_tmask = in_tmask[i*NUM_THREADS +: NUM_THREADS];
                sel_PC    = in_PC[i*32 +: 32];
                sel_wb    = in_wb[i];
                sel_rd    = in_rd[i*NR_BITS +: NR_BITS];
                sel_data  = in_data[i*DW +: DW];
                sel_eop   = in_eop[i];
            end
        end
    end

    // Output register stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid  <= 1'b0;
            wb_uuid   <= '0;
            wb_wid    <= '0;
            wb_tmask  <= '0;
            wb_PC     <= '0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_eop    <= 1'b0;
            retired   <= '0;
            rr        <= '0;
            lock      <= 1'b0;
            lock_unit <= '0;
        end else if (accept) begin
            if (sel_wb) begin
                wb_valid <= 1'b1;
                wb_uuid  <= sel_uuid;
                wb_wid   <= sel_wid;
                wb_tmask <= sel_tmask;
                wb_PC    <= sel_PC;
                wb_rd    <= sel_rd;
                wb_data  <= sel_data;
                wb_eop   <= sel_eop;
            end else if (wb_ready) begin
                wb_valid <= 1'b0;
            end
            if (sel_eop) begin
                lock    <= 1'b0;
                rr      <= next_rr;
                retired <= retired + CTR_BITS'(1);
            end else begin
                lock      <= 1'b1;
                lock_unit <= grant_idx;
            end
        end else if (wb_ready) begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vx_writeback_arbiter.sv
// Directed bench for vx_writeback_arbiter: reset, round-robin order, atomic bursts,
// back-pressure, no-writeback retirement and reset during a locked burst.
module tb_vx_writeback_arbiter;

    localparam int NU = 5;
    localparam int NT = 4;
    localparam int XL = 32;
    localparam int NW = 2;
    localparam int NR = 6;
    localparam int UB = 44;
    localparam int CB = 64;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NU-1:0]        in_valid = '0;
    logic [NU-1:0]        in_ready;
    logic [NU*UB-1:0]     in_uuid = '0;
    logic [NU*NW-1:0]     in_wid = '0;
    logic [NU*NT-1:0]     in_tmask = '0;
    logic [NU*32-1:0]     in_PC = '0;
    logic [NU-1:0]        in_wb = '0;
    logic [NU*NR-1:0]     in_rd = '0;
    logic [NU*NT*XL-1:0]  in_data = '0;
    logic [NU-1:0]        in_eop = '0;
    logic                 wb_valid;
    logic                 wb_ready = 1'b1;
    logic [UB-1:0]        wb_uuid;
    logic [NW-1:0]        wb_wid;
    logic [NT-1:0]        wb_tmask;
    logic [31:0]          wb_PC;
    logic [NR-1:0]        wb_rd;
    logic [NT*XL-1:0]     wb_data;
    logic                 wb_eop;
    logic [CB-1:0]        retired;

    int n_chk  = 0;
    int n_pass = 0;
    logic [CB-1:0] r0;

    vx_writeback_arbiter #(
        .NUM_UNITS(NU), .NUM_THREADS(NT), .XLEN(XL), .NW_BITS(NW),
        .NR_BITS(NR), .UUID_BITS(UB), .CTR_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_uuid(in_uuid), .in_wid(in_wid),
        .in_tmask(in_tmask), .in_PC(in_PC), .in_wb(in_wb), .in_rd(in_rd),
        .in_data(in_data), .in_eop(in_eop),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_uuid(wb_uuid), .wb_wid(wb_wid),
        .wb_tmask(wb_tmask), .wb_PC(wb_PC), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_eop(wb_eop), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic set_unit(input int u, input logic v, input logic wb,
                            input logic [NR-1:0] rd, input logic [7:0] d, input logic eop);
        in_valid[u]               = v;
        in_wb[u]                  = wb;
        in_rd[u*NR +: NR]         = rd;
        in_data[u*NT*XL +: NT*XL] = {NT{24'h0, d}};
        in_eop[u]                 = eop;
        in_uuid[u*UB +: UB]       = UB'(u + 1);
        in_PC[u*32 +: 32]         = 32'h1000 + 32'(u * 4);
        in_tmask[u*NT +: NT]      = 4'hF;
        in_wid[u*NW +: NW]        = NW'(u);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int u = 0; u < NU; u++) set_unit(u, 1'b1, 1'b1, NR'(u), 8'hFF, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00000) $display("FAIL reset_ready: got %b exp 00000", in_ready); else n_pass++;
        n_chk++; if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b exp 0", wb_valid); else n_pass++;
        n_chk++; if (retired !== 64'd0) $display("FAIL reset_retired: got %0d exp 0", retired); else n_pass++;
        n_chk++; if (wb_rd !== 6'd0 || wb_data !== '0) $display("FAIL reset_payload: got rd %0d data %h exp 0", wb_rd, wb_data); else n_pass++;
        in_valid = '0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        set_unit(0, 1'b1, 1'b1, 6'd5, 8'hA5, 1'b1);
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00001) $display("FAIL single_ready: got %b exp 00001", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = '0;
        n_chk++; if (wb_valid !== 1'b1) $display("FAIL single_valid: got %b exp 1", wb_valid); else n_pass++;
        n_chk++; if (wb_rd !== 6'd5) $display("FAIL single_rd: got %0d exp 5", wb_rd); else n_pass++;
        n_chk++; if (wb_data !== {4{32'h000000A5}}) $display("FAIL single_data: got %h exp A5 per thread", wb_data); else n_pass++;
        n_chk++; if (wb_PC !== 32'h1000 || wb_uuid !== 44'd1) $display("FAIL single_pc_uuid: got %h/%0d exp 1000/1", wb_PC, wb_uuid); else n_pass++;
        n_chk++; if (retired !== 64'd1) $display("FAIL single_retired: got %0d exp 1", retired); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_valid !== 1'b0) $display("FAIL single_drain: got %b exp 0", wb_valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_u;
        pulse_reset();
        for (int u = 0; u < NU; u++) set_unit(u, 1'b1, 1'b1, NR'(10 + u), 8'(u), 1'b1);
        for (int c = 0; c < 6; c++) begin
            exp_u = c % NU;
            @(negedge clk);
            n_chk++; if (in_ready !== 5'(1 << exp_u)) $display("FAIL rr_ready_%0d: got %b exp unit %0d", c, in_ready, exp_u); else n_pass++;
            @(posedge clk); #1;
            n_chk++; if (wb_valid !== 1'b1 || wb_rd !== NR'(10 + exp_u)) $display("FAIL rr_wb_%0d: got v%b rd %0d exp v1 rd %0d", c, wb_valid, wb_rd, 10 + exp_u); else n_pass++;
        end
        in_valid = '0;
        n_chk++; if (retired !== 64'd6) $display("FAIL rr_retired: got %0d exp 6", retired); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_lock();
        pulse_reset();
        set_unit(2, 1'b1, 1'b1, 6'd20, 8'h20, 1'b0);
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00100) $display("FAIL lock_p0_ready: got %b exp 00100", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_rd !== 6'd20 || wb_eop !== 1'b0 || retired !== 64'd0) $display("FAIL lock_p0_wb: got rd %0d eop %b ret %0d exp 20 0 0", wb_rd, wb_eop, retired); else n_pass++;
        set_unit(2, 1'b0, 1'b1, 6'd21, 8'h21, 1'b0);
        set_unit(0, 1'b1, 1'b1, 6'd30, 8'h30, 1'b1);
        set_unit(3, 1'b1, 1'b1, 6'd33, 8'h33, 1'b1);
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00000) $display("FAIL lock_starve: got %b exp 00000", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_valid !== 1'b0) $display("FAIL lock_gap_valid: got %b exp 0", wb_valid); else n_pass++;
        in_valid[2] = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00100) $display("FAIL lock_p1_ready: got %b exp 00100", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_rd !== 6'd21) $display("FAIL lock_p1_rd: got %0d exp 21", wb_rd); else n_pass++;
        set_unit(2, 1'b1, 1'b1, 6'd22, 8'h22, 1'b1);
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00100) $display("FAIL lock_p2_ready: got %b exp 00100", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_rd !== 6'd22 || wb_eop !== 1'b1 || retired !== 64'd1) $display("FAIL lock_p2_wb: got rd %0d eop %b ret %0d exp 22 1 1", wb_rd, wb_eop, retired); else n_pass++;
        in_valid[2] = 1'b0;
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b01000) $display("FAIL lock_next_ready: got %b exp 01000", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_rd !== 6'd33 || retired !== 64'd2) $display("FAIL lock_next_wb: got rd %0d ret %0d exp 33 2", wb_rd, retired); else n_pass++;
        in_valid[3] = 1'b0;
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00001) $display("FAIL lock_wrap_ready: got %b exp 00001", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_rd !== 6'd30) $display("FAIL lock_wrap_rd: got %0d exp 30", wb_rd); else n_pass++;
        in_valid = '0;
    endtask

    task automatic test_back_pressure();
        set_unit(0, 1'b1, 1'b1, 6'd40, 8'h40, 1'b1);
        set_unit(1, 1'b1, 1'b1, 6'd41, 8'h41, 1'b1);
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00010) $display("FAIL bp_first_ready: got %b exp 00010", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        wb_ready    = 1'b0;
        r0          = retired;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_chk++; if (in_ready !== 5'b00000) $display("FAIL bp_ready_%0d: got %b exp 00000", c, in_ready); else n_pass++;
            n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 6'd41) $display("FAIL bp_hold_%0d: got v%b rd %0d exp v1 rd 41", c, wb_valid, wb_rd); else n_pass++;
            @(posedge clk); #1;
        end
        n_chk++; if (retired !== r0) $display("FAIL bp_retired: got %0d exp %0d", retired, r0); else n_pass++;
        wb_ready = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00001) $display("FAIL bp_release_ready: got %b exp 00001", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 6'd40) $display("FAIL bp_release_wb: got v%b rd %0d exp v1 rd 40", wb_valid, wb_rd); else n_pass++;
        in_valid = '0;
    endtask

    task automatic test_no_wb();
        @(posedge clk); #1;
        n_chk++; if (wb_valid !== 1'b0) $display("FAIL nowb_idle: got %b exp 0", wb_valid); else n_pass++;
        r0 = retired;
        set_unit(1, 1'b1, 1'b0, 6'd50, 8'h50, 1'b1);
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00010) $display("FAIL nowb_ready: got %b exp 00010", in_ready); else n_pass++;
        @(posedge clk); #1;
        in_valid = '0;
        n_chk++; if (wb_valid !== 1'b0) $display("FAIL nowb_valid: got %b exp 0", wb_valid); else n_pass++;
        n_chk++; if (retired !== r0 + 64'd1) $display("FAIL nowb_retired: got %0d exp %0d", retired, r0 + 64'd1); else n_pass++;
        n_chk++; if (wb_rd !== 6'd40) $display("FAIL nowb_payload_hold: got %0d exp 40", wb_rd); else n_pass++;
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00000) $display("FAIL nowb_ready_drop: got %b exp 00000", in_ready); else n_pass++;
    endtask

    task automatic test_reset_midburst();
        @(posedge clk); #1;
        set_unit(4, 1'b1, 1'b1, 6'd60, 8'h60, 1'b0);
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b10000) $display("FAIL mid_lock_ready: got %b exp 10000", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_valid !== 1'b1 || wb_rd !== 6'd60) $display("FAIL mid_lock_wb: got v%b rd %0d exp v1 rd 60", wb_valid, wb_rd); else n_pass++;
        set_unit(4, 1'b1, 1'b1, 6'd61, 8'h61, 1'b1);
        set_unit(0, 1'b1, 1'b1, 6'd7, 8'h70, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00000) $display("FAIL mid_reset_ready: got %b exp 00000", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_valid !== 1'b0 || retired !== 64'd0 || wb_rd !== 6'd0) $display("FAIL mid_reset_state: got v%b ret %0d rd %0d exp 0 0 0", wb_valid, retired, wb_rd); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if (in_ready !== 5'b00001) $display("FAIL mid_after_ready: got %b exp 00001", in_ready); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (wb_rd !== 6'd7 || retired !== 64'd1) $display("FAIL mid_after_wb: got rd %0d ret %0d exp 7 1", wb_rd, retired); else n_pass++;
        in_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_back_pressure();
        test_no_wb();
        test_reset_midburst();
        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
